// File: rtl/chat_pkg.sv
// Shared chat serial-line definitions for the TX framer and RX deframer.
// No logic; constants, state encodings and frame-length derivation only.
// TX_PARITY_EN adds one even-parity bit per frame when defined.
package chat_pkg;

   localparam int   DEF_DATA_W = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

`ifdef TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // start + data + optional parity + stop
   function automatic int frame_bits(input int dw);
      return dw + 2 + PARITY_BITS;
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } chat_state_t;

endpackage

// File: rtl/bic.sv
// Bit identification counter: counts bit strobes within one frame, flags the last bit.
// Latency: count updates on the edge after a strobe; last_bit is combinational from the count.
// Backpressure: none; clear has priority, and the count holds at the last bit instead of wrapping.
module bic #(
   parameter int FRAME_BITS = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_strobe,
   output logic o_last_bit
);

   localparam int CNT_W = $clog2(FRAME_BITS);

   logic [CNT_W-1:0] r_cnt;

   assign o_last_bit = (r_cnt == CNT_W'(FRAME_BITS - 1));

   // bit counter: cleared per frame, advances once per strobe, saturates at the last bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_strobe && !o_last_bit) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tx_framer.sv
// Chat TX framer: serialises one character LSB-first as start, data, [parity], stop. Macro: TX_PARITY_EN.
// Latency: start bit on the line 1 cycle after load; frame ends FRAME_BITS srClock strobes after acceptance.
// Backpressure: busy/transEn high for the whole frame; load while busy is dropped silently.
module tx_framer
   import chat_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              srClock,
   output logic              transEn,
   output logic              busy,
   output logic              serial_out,
   output logic              done
);

   localparam int FRAME_BITS = frame_bits(DATA_W);

   chat_state_t           r_state;
   chat_state_t           w_next_state;
   logic [FRAME_BITS-1:0] r_shreg;
   logic [FRAME_BITS-1:0] w_frame;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_shift;
   logic                  w_finish;
   logic                  w_last_bit;

   // Frame image, bit 0 goes on the line first.
`ifdef TX_PARITY_EN
   assign w_frame = {STOP_BIT, ^data_in, data_in, START_BIT};
`else
   assign w_frame = {STOP_BIT, data_in, START_BIT};
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next state plus accept/shift/finish strobes; srClock in IDLE and load in SEND fall through
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_shift      = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_accept     = 1'b1;
               w_next_state = SEND;
            end
         end
         SEND: begin
            if (srClock) begin
               if (w_last_bit) begin
                  w_finish     = 1'b1;
                  w_next_state = IDLE;
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // shift register: load the frame image on accept, shift in stop level on each strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '1;
      end else if (w_accept) begin
         r_shreg <= w_frame;
      end else if (w_shift) begin
         r_shreg <= {STOP_BIT, r_shreg[FRAME_BITS-1:1]};
      end
   end

   // done: one-cycle pulse in the cycle after the stop bit's closing strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
      end
   end

   bic #(
      .FRAME_BITS (FRAME_BITS)
   ) u_bic (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_accept),
      .i_strobe   (w_shift),
      .o_last_bit (w_last_bit)
   );

   // Outputs decode straight from state so reset forces the idle line without a clock.
   assign transEn    = (r_state == SEND);
   assign busy       = transEn;
   assign serial_out = (r_state == SEND) ? r_shreg[0] : IDLE_LEVEL;
   assign done       = r_done;

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: reset, single frame, load while busy, back-to-back,
// stray strobes, load on the final strobe, and asynchronous reset mid-frame.
// Frame length and expected frame images follow TX_PARITY_EN.
module tb_tx_framer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] data_in;
   logic       srClock;
   logic       transEn;
   logic       busy;
   logic       serial_out;
   logic       done;

   int n_vec;
   int n_err;

`ifdef TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;   // ^A5 = 0
   localparam logic [10:0] F_FF = 11'b1_0_11111111_0;   // ^FF = 0
   localparam logic [10:0] F_07 = 11'b1_1_00000111_0;   // ^07 = 1
`else
   localparam int NB = 10;
   localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
   localparam logic [10:0] F_FF = 11'b0_1_11111111_0;
   localparam logic [10:0] F_07 = 11'b0_1_00000111_0;
`endif

   tx_framer dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .data_in    (data_in),
      .srClock    (srClock),
      .transEn    (transEn),
      .busy       (busy),
      .serial_out (serial_out),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // load a character for one cycle (only meaningful while idle)
   task automatic issue_load(input logic [7:0] d);
      load    = 1'b1;
      data_in = d;
      tick();
      load    = 1'b0;
      data_in = 8'h00;
   endtask

   // Walk one frame: each bit lasts per cycles, strobe on its last cycle; the line is
   // checked just before each strobe. Optionally fire a 3C load coinciding with strobe ld_at.
   task automatic run_frame(input string nm, input logic [10:0] exp, input int per,
                            input int ld_at, output int en_cyc);
      en_cyc = 0;
      for (int b = 0; b < NB; b++) begin
         for (int c = 0; c < per; c++) begin
            if (transEn) en_cyc++;
            if (c == per - 1)
               check_vec($sformatf("%s_bit%0d", nm, b), 32'(serial_out), 32'(exp[b]));
            srClock = (c == per - 1);
            load    = (b == ld_at) && (c == per - 1);
            data_in = load ? 8'h3C : 8'h00;
            tick();
         end
      end
      srClock = 1'b0;
      load    = 1'b0;
      data_in = 8'h00;
   endtask

   int en;

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      load    = 1'b0;
      srClock = 1'b0;
      data_in = 8'h00;

      // reset
      tick();
      rst = 1'b0;
      check_vec("rst_line", 32'(serial_out), 32'd1);
      check_vec("rst_en",   32'(transEn),    32'd0);
      check_vec("rst_busy", 32'(busy),       32'd0);
      check_vec("rst_done", 32'(done),       32'd0);

      // stray strobes while idle
      for (int i = 0; i < 3; i++) begin
         srClock = 1'b1;
         tick();
         srClock = 1'b0;
         tick();
         check_vec("stray_line", 32'(serial_out), 32'd1);
         check_vec("stray_done", 32'(done),       32'd0);
      end
      check_vec("stray_cnt", 32'(dut.u_bic.r_cnt), 32'd0);

      // single A5 frame, strobe every 16 clk
      issue_load(8'hA5);
      check_vec("a5_start_en", 32'(transEn), 32'd1);
      run_frame("a5", F_A5, 16, -1, en);
      check_vec("a5_en_cycles", 32'(en),         32'(NB * 16));
      check_vec("a5_done",      32'(done),       32'd1);
      check_vec("a5_en_drop",   32'(transEn),    32'd0);
      check_vec("a5_busy_drop", 32'(busy),       32'd0);
      check_vec("a5_idle_line", 32'(serial_out), 32'd1);
      tick();
      check_vec("a5_done_once", 32'(done), 32'd0);

      // load 3C at strobe 3 of an A5 frame: ignored
      issue_load(8'hA5);
      run_frame("busyld", F_A5, 4, 2, en);
      check_vec("busyld_done", 32'(done), 32'd1);
      for (int i = 0; i < 12; i++) tick();
      check_vec("busyld_no_2nd", 32'(transEn),    32'd0);
      check_vec("busyld_line",   32'(serial_out), 32'd1);

      // load on the final strobe: ignored
      issue_load(8'hA5);
      run_frame("lastld", F_A5, 4, NB - 1, en);
      tick();
      check_vec("lastld_no_2nd", 32'(transEn), 32'd0);

      // back-to-back: reissue FF in the done cycle
      issue_load(8'hA5);
      run_frame("b2b_a", F_A5, 4, -1, en);
      check_vec("b2b_done", 32'(done),       32'd1);
      check_vec("b2b_stop", 32'(serial_out), 32'd1);
      issue_load(8'hFF);
      check_vec("b2b_start", 32'(serial_out), 32'd0);
      check_vec("b2b_en",    32'(transEn),    32'd1);
      run_frame("b2b_ff", F_FF, 4, -1, en);
      check_vec("b2b_ff_done", 32'(done), 32'd1);
      tick();

      // 07: checks parity bit when enabled
      issue_load(8'h07);
      run_frame("x07", F_07, 3, -1, en);
      check_vec("x07_done", 32'(done), 32'd1);
      tick();

      // asynchronous reset after strobe 4 of an A5 frame (line is at data bit 3 = 0)
      issue_load(8'hA5);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            srClock = (c == 3);
            tick();
         end
      end
      srClock = 1'b0;
      check_vec("mid_pre_line", 32'(serial_out), 32'd0);
      check_vec("mid_pre_en",   32'(transEn),    32'd1);
      rst = 1'b1;
      #1;
      check_vec("mid_rst_line", 32'(serial_out),        32'd1);
      check_vec("mid_rst_en",   32'(transEn),           32'd0);
      check_vec("mid_rst_busy", 32'(busy),              32'd0);
      check_vec("mid_rst_cnt",  32'(dut.u_bic.r_cnt),   32'd0);
      rst = 1'b0;
      tick();
      check_vec("post_rst_line", 32'(serial_out), 32'd1);
      check_vec("post_rst_done", 32'(done),       32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
